lcm_pkt_arbiter: RTL
====================

// Module: lcm_pkt_arbiter
// PURPOSE
//  Packet-granular 2:1 arbiter sharing the single LCM->ESW 134-bit output between
//  port 0 (locally generated beacon report/update) and port 1 (pass-through UM path).
//  Each port has a beat FIFO and a valid-flag FIFO. Whole packets are granted
//  round-robin and streamed one beat per cycle; packets are never interleaved.
// PARAMETERS
//  FIFO_AW   4   log2 beat-FIFO depth per port (16 beats)
//  MAX_BEATS 8   largest packet in beats; gates in_pN_ready
//  VFIFO_AW  2   log2 valid-flag FIFO depth per port (4 packets)
// PORTS
//  clk                  in   1    clock
//  rst                  in   1    synchronous reset, active-high
//  in_pN_data (N=0,1)   in   134  beat; [133:132] 01=head 00=mid 10=tail 11=head+tail
//  in_pN_data_wr        in   1    beat write strobe
//  in_pN_valid          in   1    packet valid flag (0 = downstream discard)
//  in_pN_valid_wr       in   1    flag strobe; same cycle as that packet's tail beat
//  out_pN_ready         out  1    port may start a new packet
//  out_data             out  134  granted beat
//  out_data_wr          out  1    beat strobe
//  out_data_valid       out  1    forwarded packet flag
//  out_data_valid_wr    out  1    flag strobe; same cycle as output tail beat
//  in_out_ready         in   1    sampled only in IDLE, before each new grant
//  out_grant_cnt0/1     out  32   packets sent per port, wraps at 2^32
// BEHAVIOUR
//  - Reset: all outputs 0 except out_pN_ready=1; FIFOs emptied; RR pointer=0 (port 0
//    wins first tie); state IDLE. Reset mid-packet drops all buffered data.
//  - out_pN_ready = (free beats >= MAX_BEATS) && (valid FIFO not full); registered.
//    Sources only start a packet while ready is 1. A write to a full FIFO is dropped
//    and sets sticky error bit N (debug only).
//  - A packet is eligible once its valid flag is in the valid FIFO (tail written).
//  - FSM IDLE -> SEND -> IDLE:
//    IDLE: if in_out_ready and any port eligible, grant it (tie: port != last
//      granted; one contender: it wins) and go to SEND. Granting costs one cycle.
//    SEND: pop one beat per cycle to out_data with out_data_wr=1. On a tail beat
//      (10 or 11): pop valid flag, drive out_data_valid/out_data_valid_wr=1 with it,
//      increment out_grant_cntN, update RR pointer, return to IDLE.
//  - Latency: eligible idle port -> first output beat = 2 cycles. Gap between
//    back-to-back packets = 1 idle cycle.
//  - Simultaneous push/pop on one FIFO in a cycle keeps occupancy unchanged.
//    Pointers wrap mod 2^FIFO_AW / 2^VFIFO_AW.
//  - in_out_ready never stalls a packet mid-stream.
//  - Head beat (01/11) read in IDLE position is passed unchanged; no format repair.
// CONFIGURATION
//  LCM_ARB_STRICT_PRIO_EN defined: port 0 always wins when eligible. RR pointer is
//    unused; port 1 can starve.
//  Undefined: round-robin as above (default).
// TESTING
//  1. Reset, 3-beat pkt on p0 (valid=1) -> out beats at cycles t+2..t+4; valid_wr
//     with 3rd beat; out_grant_cnt0=1.
//  2. Both ports hold complete 2-beat pkts at the same time, RR -> order p0,p1,p0,p1
//     with no beat interleaving; 1 idle cycle between packets.
//  3. Fill p1 until free < MAX_BEATS -> out_p1_ready=0. Drain one pkt -> ready=1
//     on the next cycle.
//  4. in_out_ready=0 while eligible -> no output. Drop it mid-packet -> packet still
//     completes.
//  5. Single-beat pkt (11), valid=0 -> one beat with out_data_valid_wr=1,
//     out_data_valid=0.
//  6. Assert rst during SEND -> next cycle outputs 0, ready=1, FIFOs empty;
//     LCM_ARB_STRICT_PRIO_EN build: p0 wins every tie in scenario 2.

Source files
------------

// File: rtl/lcm_pkt_arbiter.sv
// lcm_pkt_arbiter: packet-granular 2:1 arbiter onto the shared LCM->ESW 134-bit bus.
// Optional build macro LCM_ARB_STRICT_PRIO_EN: fixed priority to port 0 instead of round-robin.
module lcm_pkt_arbiter #(
    parameter int FIFO_AW   = 4,
    parameter int MAX_BEATS = 8,
    parameter int VFIFO_AW  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [133:0] in_p0_data,
    input  logic         in_p0_data_wr,
    input  logic         in_p0_valid,
    input  logic         in_p0_valid_wr,
    input  logic [133:0] in_p1_data,
    input  logic         in_p1_data_wr,
    input  logic         in_p1_valid,
    input  logic         in_p1_valid_wr,
    output logic         out_p0_ready,
    output logic         out_p1_ready,
    output logic [133:0] out_data,
    output logic         out_data_wr,
    output logic         out_data_valid,
    output logic         out_data_valid_wr,
    input  logic         in_out_ready,
    output logic [31:0]  out_grant_cnt0,
    output logic [31:0]  out_grant_cnt1,
    output logic [1:0]   dbg_overflow
);
    localparam int DW = 134;
    localparam int BD = 1 << FIFO_AW;
    localparam int VD = 1 << VFIFO_AW;
    localparam logic [FIFO_AW:0]    B_FULL = (FIFO_AW + 1)'(BD);
    localparam logic [FIFO_AW:0]    B_MIN  = (FIFO_AW + 1)'(MAX_BEATS);
    localparam logic [FIFO_AW:0]    B_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0]  BP_ONE = (FIFO_AW)'(1);
    localparam logic [VFIFO_AW:0]   V_FULL = (VFIFO_AW + 1)'(VD);
    localparam logic [VFIFO_AW:0]   V_ONE  = (VFIFO_AW + 1)'(1);
    localparam logic [VFIFO_AW-1:0] VP_ONE = (VFIFO_AW)'(1);

    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t state_q, state_nxt;
    logic   gnt_q, gnt_nxt;
`ifndef LCM_ARB_STRICT_PRIO_EN
    logic   rr_q;
`endif

    logic [DW-1:0] in_data [2];
    logic [1:0]    in_wr, in_vflag, in_vwr;

    assign in_data[0] = in_p0_data;
    assign in_data[1] = in_p1_data;
    assign in_wr      = {in_p1_data_wr,  in_p0_data_wr};
    assign in_vflag   = {in_p1_valid,    in_p0_valid};
    assign in_vwr     = {in_p1_valid_wr, in_p0_valid_wr};

    logic [DW-1:0]       bmem [2][BD];
    logic                vmem [2][VD];
    logic [FIFO_AW-1:0]  b_wp [2], b_rp [2];
    logic [FIFO_AW:0]    b_cnt [2], b_cnt_nxt [2];
    logic [VFIFO_AW-1:0] v_wp [2], v_rp [2];
    logic [VFIFO_AW:0]   v_cnt [2], v_cnt_nxt [2];

    logic [1:0]    b_push, b_pop, v_push, v_pop, eligible, ready_q;
    logic [DW-1:0] head_beat;
    logic          head_vld, tx_beat, tail_pop;

    assign head_beat = bmem[gnt_q][b_rp[gnt_q]];
    assign head_vld  = vmem[gnt_q][v_rp[gnt_q]];
    assign tx_beat   = (state_q == ST_SEND) && (b_cnt[gnt_q] != '0);
    assign tail_pop  = tx_beat && head_beat[DW-1];

    assign out_p0_ready = ready_q[0];
    assign out_p1_ready = ready_q[1];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            b_push[p]   = in_wr[p]  && (b_cnt[p] != B_FULL);
            v_push[p]   = in_vwr[p] && (v_cnt[p] != V_FULL);
            b_pop[p]    = tx_beat  && (gnt_q == 1'(p));
            v_pop[p]    = tail_pop && (gnt_q == 1'(p)) && (v_cnt[p] != '0);
            eligible[p] = (v_cnt[p] != '0);

            b_cnt_nxt[p] = b_cnt[p];
            if (b_push[p] && !b_pop[p])
                b_cnt_nxt[p] = b_cnt[p] + B_ONE;
            else if (!b_push[p] && b_pop[p])
                b_cnt_nxt[p] = b_cnt[p] - B_ONE;

            v_cnt_nxt[p] = v_cnt[p];
            if (v_push[p] && !v_pop[p])
                v_cnt_nxt[p] = v_cnt[p] + V_ONE;
            else if (!v_push[p] && v_pop[p])
                v_cnt_nxt[p] = v_cnt[p] - V_ONE;
        end
    end

    always_comb begin
        state_nxt = state_q;
        gnt_nxt   = gnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // A new grant is only taken between packets; in_out_ready is ignored mid-stream.
                if (in_out_ready && (eligible != 2'b00)) begin
                    state_nxt = ST_SEND;
`ifdef LCM_ARB_STRICT_PRIO_EN
                    gnt_nxt = !eligible[0];
`else
                    gnt_nxt = (eligible == 2'b11) ? rr_q : eligible[1];
`endif
                end
            end
            ST_SEND: begin
                if (tail_pop)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            gnt_q             <= 1'b0;
`ifndef LCM_ARB_STRICT_PRIO_EN
            rr_q              <= 1'b0;
`endif
            for (int p = 0; p < 2; p++) begin
                b_wp[p]  <= '0;
                b_rp[p]  <= '0;
                b_cnt[p] <= '0;
                v_wp[p]  <= '0;
                v_rp[p]  <= '0;
                v_cnt[p] <= '0;
            end
            ready_q           <= 2'b11;
            out_data          <= '0;
            out_data_wr       <= 1'b0;
            out_data_valid    <= 1'b0;
            out_data_valid_wr <= 1'b0;
            out_grant_cnt0    <= '0;
            out_grant_cnt1    <= '0;
            dbg_overflow      <= '0;
        end else begin
            state_q <= state_nxt;
            gnt_q   <= gnt_nxt;
`ifndef LCM_ARB_STRICT_PRIO_EN
            if (tail_pop)
                rr_q <= !gnt_q;
`endif
            for (int p = 0; p < 2; p++) begin
                if (b_push[p]) b_wp[p] <= b_wp[p] + BP_ONE;
                if (b_pop[p])  b_rp[p] <= b_rp[p] + BP_ONE;
                if (v_push[p]) v_wp[p] <= v_wp[p] + VP_ONE;
                if (v_pop[p])  v_rp[p] <= v_rp[p] + VP_ONE;
                b_cnt[p] <= b_cnt_nxt[p];
                v_cnt[p] <= v_cnt_nxt[p];
                // Ready tracks post-update occupancy so it reopens as soon as space is freed.
                ready_q[p] <= ((B_FULL - b_cnt_nxt[p]) >= B_MIN) && (v_cnt_nxt[p] != V_FULL);
                if ((in_wr[p] && !b_push[p]) || (in_vwr[p] && !v_push[p]))
                    dbg_overflow[p] <= 1'b1;
            end
            out_data_wr       <= tx_beat;
            out_data          <= tx_beat ? head_beat : '0;
            out_data_valid_wr <= tail_pop;
            out_data_valid    <= tail_pop && head_vld;
            if (v_pop[0]) out_grant_cnt0 <= out_grant_cnt0 + 32'd1;
            if (v_pop[1]) out_grant_cnt1 <= out_grant_cnt1 + 32'd1;
        end
    end

    // NOTE: storage arrays are not reset; pointers and counts alone define valid contents.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (b_push[p]) bmem[p][b_wp[p]] <= in_data[p];
            if (v_push[p]) vmem[p][v_wp[p]] <= in_vflag[p];
        end
    end

endmodule
